helloworld: RTL and testbench

HELLOWORLD -- requirements
Module: helloworld

---
 rtl/helloworld_pkg.sv | 73 +++++++
 rtl/helloworld_lcd_byte_writer.sv | 98 +++++++++
 rtl/helloworld.sv | 107 ++++++++++
 tb/tb_helloworld.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/helloworld_pkg.sv
// Shared constants for the HD44780 "Hello World!" writer: command bytes,
// message ROM, delay table and cycle-conversion helpers.
package helloworld_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_DDRAM0   = 8'h80;

  localparam int NUM_CMDS = 8;
  localparam int MSG_LEN  = 12;
  localparam int SEQ_LEN  = NUM_CMDS + MSG_LEN;

  localparam logic [7:0] MSG_ROM [MSG_LEN] = '{
    8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
    8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21
  };

  localparam longint unsigned DLY_5MS_US   = 64'd5000;
  localparam longint unsigned DLY_200US_US = 64'd200;
  localparam longint unsigned DLY_50US_US  = 64'd50;
  localparam longint unsigned DLY_2MS_US   = 64'd2000;
  localparam longint unsigned E_PULSE_NS   = 64'd500;

  typedef enum logic [2:0] {
    ST_POWERUP, ST_SETUP, ST_PULSE, ST_WAIT, ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    W_IDLE, W_SETUP, W_PULSE, W_HOLD
  } wphase_e;

  typedef enum logic [1:0] {
    DLY_5MS, DLY_200US, DLY_50US, DLY_2MS
  } dly_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    dly_e       dly;
  } seq_entry_t;

  function automatic longint unsigned us_to_cyc(input longint unsigned us,
                                                input longint unsigned hz);
    return (us * hz + 64'd999_999) / 64'd1_000_000;
  endfunction

  function automatic longint unsigned ns_to_cyc(input longint unsigned ns,
                                                input longint unsigned hz);
    return (ns * hz + 64'd999_999_999) / 64'd1_000_000_000;
  endfunction

  // The three leading 0x38 writes are the HD44780 reset-by-instruction dance.
  function automatic seq_entry_t seq_entry(input logic [4:0] idx);
    seq_entry_t e;
    logic [3:0] m;
    m = 4'(idx - 5'd8);
    case (idx)
      5'd0:    e = '{1'b0, CMD_FUNC_SET, DLY_5MS};
      5'd1:    e = '{1'b0, CMD_FUNC_SET, DLY_200US};
      5'd2:    e = '{1'b0, CMD_FUNC_SET, DLY_50US};
      5'd3:    e = '{1'b0, CMD_FUNC_SET, DLY_50US};
      5'd4:    e = '{1'b0, CMD_DISP_ON,  DLY_50US};
      5'd5:    e = '{1'b0, CMD_CLEAR,    DLY_2MS};
      5'd6:    e = '{1'b0, CMD_ENTRY,    DLY_50US};
      5'd7:    e = '{1'b0, CMD_DDRAM0,   DLY_50US};
      default: e = '{1'b1, MSG_ROM[m],   DLY_50US};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/helloworld_lcd_byte_writer.sv
// One HD44780 write: 1 setup cycle, PULSE_CYC cycles of E high, then E low
// with RS/data held for wait_cycles_i cycles. A new start may be accepted on done.
module lcd_byte_writer
  import helloworld_pkg::*;
#(
  parameter int CNT_W     = 18,
  parameter int PULSE_CYC = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             rs_i,
  input  logic [7:0]       data_i,
  input  logic [CNT_W-1:0] wait_cycles_i,
  output logic             lcd_rs_o,
  output logic             lcd_e_o,
  output logic [7:0]       lcd_data_o,
  output logic             pulse_end_o,
  output logic             done_o
);

  wphase_e          phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             rs_q, rs_d;
  logic             e_q, e_d;
  logic [7:0]       data_q, data_d;
  logic             accept;

  assign pulse_end_o = (phase_q == W_PULSE) && (cnt_q == CNT_W'(PULSE_CYC - 1));
  assign done_o      = (phase_q == W_HOLD) && (cnt_q == wait_q - CNT_W'(1));
  assign accept      = start_i && ((phase_q == W_IDLE) || done_o);

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    rs_d    = rs_q;
    e_d     = e_q;
    data_d  = data_q;
    if (accept) begin
      phase_d = W_SETUP;
      rs_d    = rs_i;
      data_d  = data_i;
      wait_d  = wait_cycles_i;
      cnt_d   = '0;
    end else begin
      case (phase_q)
        W_SETUP: begin
          phase_d = W_PULSE;
          e_d     = 1'b1;
          cnt_d   = '0;
        end
        W_PULSE: begin
          if (pulse_end_o) begin
            phase_d = W_HOLD;
            e_d     = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        W_HOLD: begin
          if (done_o) begin
            phase_d = W_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= W_IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      rs_q    <= rs_d;
      e_q     <= e_d;
      data_q  <= data_d;
    end
  end

  assign lcd_rs_o   = rs_q;
  assign lcd_e_o    = e_q;
  assign lcd_data_o = data_q;

endmodule

// File: rtl/helloworld.sv
// Drives an HD44780 in 8-bit mode through its init sequence, then writes
// "Hello World!" once and parks in DONE with E low.
module helloworld
  import helloworld_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 8000000,
  parameter int unsigned POWERUP_US  = 20000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic       lcd_rs_o,
  output logic       lcd_e_o,
  output logic [7:0] lcd_databus_o
);

  localparam longint unsigned HZ         = 64'(CLK_FREQ_HZ);
  localparam longint unsigned PWR_CYC    = us_to_cyc(64'(POWERUP_US), HZ);
  localparam longint unsigned W5MS_CYC   = us_to_cyc(DLY_5MS_US, HZ);
  localparam longint unsigned W200US_CYC = us_to_cyc(DLY_200US_US, HZ);
  localparam longint unsigned W50US_CYC  = us_to_cyc(DLY_50US_US, HZ);
  localparam longint unsigned W2MS_CYC   = us_to_cyc(DLY_2MS_US, HZ);
  localparam longint unsigned PULSE_L    = ns_to_cyc(E_PULSE_NS, HZ);
  localparam int              PULSE_CYC  = (PULSE_L < 64'd1) ? 1 : int'(PULSE_L);
  localparam longint unsigned MAX_CYC    = (PWR_CYC > W5MS_CYC) ? PWR_CYC : W5MS_CYC;
  localparam int              CNT_W      = $clog2(MAX_CYC + 64'd1);

  state_e           state_q;
  logic [4:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;

  logic [4:0]       sel_idx;
  seq_entry_t       entry;
  logic [CNT_W-1:0] wait_cyc;
  logic             pwr_done;
  logic             more;
  logic             wr_start;
  logic             wr_pulse_end;
  logic             wr_done;

  // The byte to launch next: index 0 out of power-up, otherwise the successor.
  assign sel_idx  = (state_q == ST_POWERUP) ? 5'd0 : idx_q + 5'd1;
  assign entry    = seq_entry(sel_idx);
  assign pwr_done = (state_q == ST_POWERUP) && (cnt_q == CNT_W'(PWR_CYC - 64'd1));
  assign more     = (idx_q != 5'(SEQ_LEN - 1));
  assign wr_start = pwr_done || ((state_q == ST_WAIT) && wr_done && more);

  always_comb begin
    wait_cyc = CNT_W'(W50US_CYC);
    case (entry.dly)
      DLY_5MS:   wait_cyc = CNT_W'(W5MS_CYC);
      DLY_200US: wait_cyc = CNT_W'(W200US_CYC);
      DLY_2MS:   wait_cyc = CNT_W'(W2MS_CYC);
      default:   wait_cyc = CNT_W'(W50US_CYC);
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_POWERUP;
      idx_q   <= 5'd0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_POWERUP: begin
          if (pwr_done) begin
            state_q <= ST_SETUP;
            idx_q   <= 5'd0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_SETUP: state_q <= ST_PULSE;
        ST_PULSE: if (wr_pulse_end) state_q <= ST_WAIT;
        ST_WAIT: begin
          if (wr_done) begin
            if (more) begin
              state_q <= ST_SETUP;
              idx_q   <= idx_q + 5'd1;
            end else begin
              state_q <= ST_DONE;
            end
          end
        end
        default: state_q <= ST_DONE;
      endcase
    end
  end

  lcd_byte_writer #(
    .CNT_W    (CNT_W),
    .PULSE_CYC(PULSE_CYC)
  ) u_writer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (wr_start),
    .rs_i         (entry.rs),
    .data_i       (entry.data),
    .wait_cycles_i(wait_cyc),
    .lcd_rs_o     (lcd_rs_o),
    .lcd_e_o      (lcd_e_o),
    .lcd_data_o   (lcd_databus_o),
    .pulse_end_o  (wr_pulse_end),
    .done_o       (wr_done)
  );

endmodule

// File: tb/tb_helloworld.sv
// Scoreboard bench for helloworld at 2.5 MHz with a 200 us power-up wait,
// including an HD44780 DDRAM model fed on E falling edges.
module tb_helloworld;

  // 2.5 MHz: power-up 500, 5 ms 12500, 200 us 500, 50 us 125, 2 ms 5000, E pulse 2
  localparam int PWR   = 500;
  localparam int PULSE = 2;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       lcd_rs_o;
  logic       lcd_e_o;
  logic [7:0] lcd_databus_o;

  always #5 clk = ~clk;

  helloworld #(.CLK_FREQ_HZ(2500000), .POWERUP_US(200)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .lcd_rs_o     (lcd_rs_o),
    .lcd_e_o      (lcd_e_o),
    .lcd_databus_o(lcd_databus_o)
  );

  logic [8:0] exp_bytes [20] = '{
    9'h038, 9'h038, 9'h038, 9'h038, 9'h00C, 9'h001, 9'h006, 9'h080,
    9'h148, 9'h165, 9'h16C, 9'h16C, 9'h16F, 9'h120, 9'h157, 9'h16F,
    9'h172, 9'h16C, 9'h164, 9'h121
  };
  int exp_wait [20] = '{
    12500, 500, 125, 125, 125, 5000, 125, 125,
    125, 125, 125, 125, 125, 125, 125, 125, 125, 125, 125, 125
  };
  logic [7:0] exp_msg [12] = '{
    8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
    8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21
  };

  logic [8:0] sb_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rel_cyc  = 0;
  int n_falls  = 0;

  logic [7:0] ddram [80];
  int         dd_addr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pulse timing, bus stability, scoreboard pop and LCD model on each E fall.
  initial begin
    logic       prev_e;
    logic [8:0] prev_bus, cur, rise_bus, got;
    int         rise_cyc, prev_fall, last_chg;
    bit         have_fall;
    prev_e = 1'b0; prev_bus = '0; rise_bus = '0;
    rise_cyc = 0; prev_fall = 0; last_chg = 0; have_fall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        prev_e = 1'b0; prev_bus = '0; n_falls = 0; have_fall = 1'b0; last_chg = cyc;
        continue;
      end
      cur = {lcd_rs_o, lcd_databus_o};
      if (!lcd_e_o && cur != prev_bus) last_chg = cyc;
      if (lcd_e_o && !prev_e) begin
        rise_cyc = cyc;
        rise_bus = cur;
        check("bus_stable_before_rise", cur == prev_bus, cur, prev_bus);
        if (have_fall)
          check("bus_held_during_wait", (last_chg <= prev_fall) || (last_chg == cyc - 1),
                last_chg, cyc - 1);
        if (n_falls == 0)
          check("first_rise_delay", (cyc - rel_cyc >= PWR) && (cyc - rel_cyc <= PWR + 2),
                cyc - rel_cyc, PWR + 1);
      end else if (lcd_e_o && prev_e) begin
        check("bus_stable_in_pulse", cur == rise_bus, cur, rise_bus);
      end else if (!lcd_e_o && prev_e) begin
        check("pulse_width", cyc - rise_cyc == PULSE, cyc - rise_cyc, PULSE);
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", 1'b0, cur, 0);
        end else begin
          got = sb_q.pop_front();
          check("byte_rs_data", cur == got, cur, got);
        end
        if (have_fall && n_falls > 0 && n_falls < 20)
          check("fall_spacing", cyc - prev_fall == exp_wait[n_falls-1] + 1 + PULSE,
                cyc - prev_fall, exp_wait[n_falls-1] + 1 + PULSE);
        if (!cur[8]) begin
          if (cur[7:0] == 8'h01) begin
            for (int i = 0; i < 80; i++) ddram[i] = 8'h20;
            dd_addr = 0;
          end else if (cur[7]) begin
            dd_addr = int'(cur[6:0]) % 80;
          end
        end else begin
          ddram[dd_addr] = cur[7:0];
          dd_addr = (dd_addr + 1) % 80;
        end
        n_falls++;
        have_fall = 1'b1;
        prev_fall = cyc;
      end
      prev_e   = lcd_e_o;
      prev_bus = cur;
    end
  end

  task automatic push_sequence();
    for (int i = 0; i < 20; i++) sb_q.push_back(exp_bytes[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rs"},   lcd_rs_o == 1'b0,       lcd_rs_o, 0);
    check({tag, "_e"},    lcd_e_o == 1'b0,        lcd_e_o, 0);
    check({tag, "_data"}, lcd_databus_o == 8'h00, lcd_databus_o, 0);
  endtask

  initial begin
    int  i;
    bit  hit;
    for (int k = 0; k < 80; k++) ddram[k] = 8'h00;
    rst_ni = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset1");
    rst_ni  = 1'b1;
    rel_cyc = cyc;
    push_sequence();

    // Run until the 5th message character is mid-pulse, then pull reset.
    hit = 1'b0;
    for (i = 0; i < 30000 && !hit; i++) begin
      @(negedge clk); #1;
      hit = (n_falls == 12) && lcd_e_o;
    end
    check("reach_5th_char_pulse", hit, i, 0);
    rst_ni = 1'b0;
    #1;
    check("async_e_drop", lcd_e_o == 1'b0, lcd_e_o, 0);
    check("bytes_left_at_reset", sb_q.size() == 8, sb_q.size(), 8);
    sb_q.delete();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset2");

    rst_ni  = 1'b1;
    rel_cyc = cyc;
    push_sequence();
    hit = 1'b0;
    for (i = 0; i < 30000 && !hit; i++) begin
      @(negedge clk); #1;
      hit = (sb_q.size() == 0);
    end
    check("sequence_complete", hit, sb_q.size(), 0);

    repeat (2200) @(negedge clk);
    check("done_e_low",   lcd_e_o == 1'b0,       lcd_e_o, 0);
    check("done_rs",      lcd_rs_o == 1'b1,      lcd_rs_o, 1);
    check("done_data",    lcd_databus_o == 8'h21, lcd_databus_o, 8'h21);
    check("total_pulses", n_falls == 20,         n_falls, 20);
    for (int k = 0; k < 12; k++)
      check("ddram_line1", ddram[k] == exp_msg[k], ddram[k], exp_msg[k]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
